// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for a 5-stage in-order pipeline.
// Generates the enable/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB
// pipeline registers plus the PC update enable. Handles load-use hazards,
// EX-stage redirects, instruction-fetch wait states and multi-cycle data
// memory accesses (with a bounded wait that ends in a bus error pulse).
// A saturating counter tracks the number of cycles in which the PC held.
//
// Downstream register semantics: a flush wins over the enable, so a flushed
// register loads a bubble whatever its enable says.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int unsigned TIMEOUT = 16,   // legal range 2..255
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,          // asynchronous, active-low
   input  logic [4:0]       rs1_ID,
   input  logic [4:0]       rs2_ID,
   input  logic             use_rs1_ID,
   input  logic             use_rs2_ID,
   input  logic [4:0]       rd_EX,
   input  logic             mem_read_EX,
   input  logic             redirect_EX,
   input  logic             if_ack,
   input  logic             mem_req_MEM,
   input  logic             mem_ack,
   output logic             pc_en,
   output logic             en_IFID,
   output logic             en_IDEX,
   output logic             en_EXMEM,
   output logic             en_MEMWB,
   output logic             flush_IFID,
   output logic             flush_IDEX,
   output logic             flush_EXMEM,
   output logic             bus_err,
   output logic [CNT_W-1:0] stall_cycles
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   // Last wait-counter value before the access is declared dead.
   localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
   localparam logic [7:0]       WAIT_ONE  = 8'd1;
   localparam logic [7:0]       WAIT_ZERO = 8'd0;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   state_t           state_q,   state_d;
   logic [7:0]       wait_q,    wait_d;
   logic             bus_err_q, bus_err_d;
   logic [CNT_W-1:0] stall_q,   stall_d;

   // ------------------------------------------------------------------------
   // Combinational decode
   // ------------------------------------------------------------------------
   logic load_use_s;
   logic timeout_s;
   logic freeze_s;

   logic pc_en_s;
   logic en_ifid_s;
   logic en_idex_s;
   logic en_exmem_s;
   logic en_memwb_s;
   logic flush_ifid_s;
   logic flush_idex_s;
   logic flush_exmem_s;

   // Hazard, timeout and freeze detection from current state and inputs.
   always_comb begin
      load_use_s = 1'b0;
      timeout_s  = 1'b0;
      freeze_s   = 1'b0;

      // A load into x0 never creates a dependency.
      if (mem_read_EX && (rd_EX != 5'd0)) begin
         load_use_s = (use_rs1_ID && (rs1_ID == rd_EX)) ||
                      (use_rs2_ID && (rs2_ID == rd_EX));
      end else begin
         load_use_s = 1'b0;
      end

      case (state_q)
         ST_RUN: begin
            timeout_s = 1'b0;
            freeze_s  = mem_req_MEM && !mem_ack;
         end
         ST_MEM_WAIT: begin
            timeout_s = !mem_ack && (wait_q == WAIT_LAST);
            freeze_s  = !mem_ack && (wait_q != WAIT_LAST);
         end
         default: begin
            timeout_s = 1'b0;
            freeze_s  = 1'b0;
         end
      endcase
   end

   // Enable/flush generation; memory freeze outranks every other condition.
   always_comb begin
      pc_en_s       = 1'b0;
      en_ifid_s     = 1'b0;
      en_idex_s     = 1'b0;
      en_exmem_s    = 1'b0;
      en_memwb_s    = 1'b0;
      flush_ifid_s  = 1'b0;
      flush_idex_s  = 1'b0;
      flush_exmem_s = 1'b0;

      if (!rst) begin
         // Everything held quiet while in reset.
         pc_en_s = 1'b0;
      end else if (timeout_s) begin
         // Drop the dead access: it moves on into MEM/WB as a bubble while
         // everything upstream of MEM stays frozen.
         en_exmem_s    = 1'b1;
         en_memwb_s    = 1'b1;
         flush_exmem_s = 1'b1;
      end else if (freeze_s) begin
         // Whole pipe holds; upstream hazards are re-evaluated on release
         // since the registers kept their contents.
         pc_en_s = 1'b0;
      end else if (redirect_EX) begin
         // Younger instructions are wrong-path, so no stall is needed for them.
         pc_en_s      = 1'b1;
         en_ifid_s    = 1'b1;
         en_idex_s    = 1'b1;
         en_exmem_s   = 1'b1;
         en_memwb_s   = 1'b1;
         flush_ifid_s = 1'b1;
         flush_idex_s = 1'b1;
      end else if (load_use_s) begin
         // Hold PC and IF/ID, insert one bubble into EX; the load moves on.
         en_idex_s    = 1'b1;
         en_exmem_s   = 1'b1;
         en_memwb_s   = 1'b1;
         flush_idex_s = 1'b1;
      end else if (!if_ack) begin
         // No fetched word: keep the PC, feed a bubble into IF/ID.
         en_ifid_s    = 1'b1;
         en_idex_s    = 1'b1;
         en_exmem_s   = 1'b1;
         en_memwb_s   = 1'b1;
         flush_ifid_s = 1'b1;
      end else begin
         pc_en_s    = 1'b1;
         en_ifid_s  = 1'b1;
         en_idex_s  = 1'b1;
         en_exmem_s = 1'b1;
         en_memwb_s = 1'b1;
      end
   end

   // Next-state, wait counter and bus error pulse for the memory sequencer.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      bus_err_d = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_req_MEM && !mem_ack) begin
               state_d = ST_MEM_WAIT;
               wait_d  = WAIT_ONE;
            end else begin
               state_d = ST_RUN;
               wait_d  = WAIT_ZERO;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ack) begin
               state_d = ST_RUN;
               wait_d  = WAIT_ZERO;
            end else if (timeout_s) begin
               state_d   = ST_RUN;
               wait_d    = WAIT_ZERO;
               bus_err_d = 1'b1;
            end else begin
               state_d = ST_MEM_WAIT;
               wait_d  = wait_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
            wait_d  = WAIT_ZERO;
         end
      endcase
   end

   // Saturating count of cycles in which the PC did not advance.
   always_comb begin
      stall_d = stall_q;
      if (!pc_en_s && (stall_q != CNT_MAX)) begin
         stall_d = stall_q + CNT_ONE;
      end else begin
         stall_d = stall_q;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         wait_q    <= WAIT_ZERO;
         bus_err_q <= 1'b0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         bus_err_q <= bus_err_d;
         stall_q   <= stall_d;
      end
   end

   // ------------------------------------------------------------------------
   // Output drive
   // ------------------------------------------------------------------------
   assign pc_en        = pc_en_s;
   assign en_IFID      = en_ifid_s;
   assign en_IDEX      = en_idex_s;
   assign en_EXMEM     = en_exmem_s;
   assign en_MEMWB     = en_memwb_s;
   assign flush_IFID   = flush_ifid_s;
   assign flush_IDEX   = flush_idex_s;
   assign flush_EXMEM  = flush_exmem_s;
   assign bus_err      = bus_err_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed scoreboard bench for pipeline_ctrl (TIMEOUT=4, CNT_W=4).
// The driver sets inputs on each falling edge and queues the hand-computed
// output vector and stall count expected for that cycle; the monitor checks
// the DUT shortly after every falling edge against the queue head.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam int unsigned TMO = 4;
   localparam int unsigned CW  = 4;

   // Output vector: {pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
   //                 flush_IFID, flush_IDEX, flush_EXMEM, bus_err}
   localparam logic [8:0] O_ZERO = 9'b0_0000_000_0;
   localparam logic [8:0] O_RUN  = 9'b1_1111_000_0;
   localparam logic [8:0] O_BERR = 9'b1_1111_000_1;
   localparam logic [8:0] O_LU   = 9'b0_0111_010_0;
   localparam logic [8:0] O_IFW  = 9'b0_1111_100_0;
   localparam logic [8:0] O_RED  = 9'b1_1111_110_0;
   localparam logic [8:0] O_TMO  = 9'b0_0011_001_0;

   typedef struct packed {
      logic [8:0]  o;
      logic [3:0]  c;
      logic [15:0] id;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    rs1_ID, rs2_ID, rd_EX;
   logic          use_rs1_ID, use_rs2_ID, mem_read_EX, redirect_EX;
   logic          if_ack, mem_req_MEM, mem_ack;
   logic          pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB;
   logic          flush_IFID, flush_IDEX, flush_EXMEM, bus_err;
   logic [CW-1:0] stall_cycles;

   exp_t        exp_q[$];
   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [15:0] vec_id   = 16'd0;

   pipeline_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .rs1_ID       (rs1_ID),
      .rs2_ID       (rs2_ID),
      .use_rs1_ID   (use_rs1_ID),
      .use_rs2_ID   (use_rs2_ID),
      .rd_EX        (rd_EX),
      .mem_read_EX  (mem_read_EX),
      .redirect_EX  (redirect_EX),
      .if_ack       (if_ack),
      .mem_req_MEM  (mem_req_MEM),
      .mem_ack      (mem_ack),
      .pc_en        (pc_en),
      .en_IFID      (en_IFID),
      .en_IDEX      (en_IDEX),
      .en_EXMEM     (en_EXMEM),
      .en_MEMWB     (en_MEMWB),
      .flush_IFID   (flush_IFID),
      .flush_IDEX   (flush_IDEX),
      .flush_EXMEM  (flush_EXMEM),
      .bus_err      (bus_err),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [8:0] eo, input logic [3:0] ec);
      exp_t e;
      e.o    = eo;
      e.c    = ec;
      e.id   = vec_id;
      vec_id = vec_id + 16'd1;
      exp_q.push_back(e);
   endtask

   task automatic set_idle();
      rs1_ID      = 5'd0;
      rs2_ID      = 5'd0;
      rd_EX       = 5'd0;
      use_rs1_ID  = 1'b0;
      use_rs2_ID  = 1'b0;
      mem_read_EX = 1'b0;
      redirect_EX = 1'b0;
      if_ack      = 1'b1;
      mem_req_MEM = 1'b0;
      mem_ack     = 1'b0;
   endtask

   // Monitor: compare DUT outputs against the queue head every cycle.
   initial begin : monitor
      exp_t        e;
      logic [8:0]  act;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
                   flush_IFID, flush_IDEX, flush_EXMEM, bus_err};
            checks = checks + 1;
            if ((act !== e.o) || (stall_cycles !== e.c)) begin
               failures = failures + 1;
               $display("FAIL vec%0d outputs got %b cnt %0d expected %b cnt %0d",
                        e.id, act, stall_cycles, e.o, e.c);
            end
         end
      end
   end

   // Driver: directed stimulus with hand-computed expectations.
   initial begin : driver
      int unsigned n;
      rst = 1'b0;
      set_idle();

      // Reset: outputs quiet even with active requests.
      @(negedge clk); push(O_ZERO, 4'd0);
      @(negedge clk); mem_req_MEM = 1'b1; redirect_EX = 1'b1; push(O_ZERO, 4'd0);
      @(negedge clk); set_idle(); rst = 1'b1; push(O_RUN, 4'd0);
      @(negedge clk); push(O_RUN, 4'd0);

      // Load-use via rs2, exactly one bubble.
      @(negedge clk); mem_read_EX = 1'b1; rd_EX = 5'd5; rs2_ID = 5'd5; use_rs2_ID = 1'b1;
      push(O_LU, 4'd0);
      @(negedge clk); set_idle(); push(O_RUN, 4'd1);
      // Load into x0: no hazard.
      @(negedge clk); mem_read_EX = 1'b1; rd_EX = 5'd0; rs2_ID = 5'd0; use_rs2_ID = 1'b1;
      push(O_RUN, 4'd1);
      // Load-use via rs1.
      @(negedge clk); set_idle(); mem_read_EX = 1'b1; rd_EX = 5'd7; rs1_ID = 5'd7; use_rs1_ID = 1'b1;
      push(O_LU, 4'd1);
      // Matching rs1 that is not read.
      @(negedge clk); use_rs1_ID = 1'b0; push(O_RUN, 4'd2);
      // Load-use wins over fetch wait: IF/ID held, not flushed.
      @(negedge clk); use_rs1_ID = 1'b1; if_ack = 1'b0; push(O_LU, 4'd2);
      // Fetch wait alone.
      @(negedge clk); set_idle(); if_ack = 1'b0; push(O_IFW, 4'd3);
      @(negedge clk); set_idle(); push(O_RUN, 4'd4);

      // Data-memory wait: three frozen cycles then ack.
      @(negedge clk); mem_req_MEM = 1'b1; mem_ack = 1'b0; push(O_ZERO, 4'd4);
      @(negedge clk); push(O_ZERO, 4'd5);
      @(negedge clk); push(O_ZERO, 4'd6);
      @(negedge clk); mem_ack = 1'b1; push(O_RUN, 4'd7);
      // Back in RUN: ack low without request must not freeze.
      @(negedge clk); set_idle(); push(O_RUN, 4'd7);
      // Single-cycle access.
      @(negedge clk); mem_req_MEM = 1'b1; mem_ack = 1'b1; push(O_RUN, 4'd7);
      @(negedge clk); set_idle(); push(O_RUN, 4'd7);

      // Timeout: three frozen cycles, timeout cycle, one bus_err pulse.
      @(negedge clk); mem_req_MEM = 1'b1; mem_ack = 1'b0; push(O_ZERO, 4'd7);
      @(negedge clk); push(O_ZERO, 4'd8);
      @(negedge clk); push(O_ZERO, 4'd9);
      @(negedge clk); push(O_TMO, 4'd10);
      @(negedge clk); set_idle(); push(O_BERR, 4'd11);
      @(negedge clk); push(O_RUN, 4'd11);

      // Priority: redirect over load-use and fetch wait.
      @(negedge clk); redirect_EX = 1'b1; mem_read_EX = 1'b1; rd_EX = 5'd5;
      rs2_ID = 5'd5; use_rs2_ID = 1'b1; if_ack = 1'b0;
      push(O_RED, 4'd11);
      // Same with a pending memory access: full freeze.
      @(negedge clk); mem_req_MEM = 1'b1; mem_ack = 1'b0; push(O_ZERO, 4'd11);
      // Release: redirect re-evaluated.
      @(negedge clk); mem_ack = 1'b1; push(O_RED, 4'd12);
      @(negedge clk); set_idle(); push(O_RUN, 4'd12);

      // Saturation: 20 fetch-wait cycles, count sticks at 15.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if_ack = 1'b0;
         n = 12 + i;
         if (n > 15) n = 15;
         push(O_IFW, 4'(n));
      end
      @(negedge clk); set_idle(); push(O_RUN, 4'd15);

      // Reset in the middle of MEM_WAIT.
      @(negedge clk); mem_req_MEM = 1'b1; mem_ack = 1'b0; push(O_ZERO, 4'd15);
      @(negedge clk); push(O_ZERO, 4'd15);
      @(negedge clk); rst = 1'b0; push(O_ZERO, 4'd0);
      @(negedge clk); rst = 1'b1; set_idle(); push(O_RUN, 4'd0);
      @(negedge clk); push(O_RUN, 4'd0);
      @(negedge clk); push(O_RUN, 4'd0);

      // Drain the scoreboard with a bounded wait.
      n = 0;
      while ((exp_q.size() > 0) && (n < 10)) begin
         @(negedge clk);
         n = n + 1;
      end
      #5;
      if (exp_q.size() > 0) begin
         failures = failures + 1;
         $display("FAIL drain pending %0d expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
